// File: rtl/hex_display_pkg.sv
// rtl/hex_display_pkg.sv - shared types and helpers for the hex display arbiter
package hex_display_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_GAP} disp_state_t;

  // Counter width able to hold cycles-1; never narrower than one bit
  function automatic int cnt_width(input int cycles);
    return (cycles > 2) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin picker starting after the last winner
module rr_picker #(
  parameter int NUM_REQ = 3,
  parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      idx,
  output logic               valid
);

  logic [IW-1:0] cand;

  // Scan from last+1 upward with wrap; the first requester found wins
  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IW'((int'(last) + k) % NUM_REQ);
      if (!valid && req[cand]) begin
        valid       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/hex_display_arbiter.sv
// rtl/hex_display_arbiter.sv - time-shares the hex digits between requesters
module hex_display_arbiter
  import hex_display_pkg::*;
#(
  parameter int NUM_HEX     = 6,
  parameter int NUM_REQ     = 3,
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int GAP_CYCLES  = 2
) (
  input  logic                         i_clock,
  input  logic                         i_reset,
  input  logic [NUM_REQ-1:0]           i_req,
  input  logic [NUM_REQ*NUM_HEX*4-1:0] i_hex_data,
  input  logic                         i_next,
  output logic [NUM_REQ-1:0]           o_grant,
  output logic [NUM_HEX*4-1:0]         o_hex,
  output logic                         o_enable,
  output logic                         o_busy
);

  localparam int DW  = NUM_HEX * 4;
  localparam int IW  = $clog2(NUM_REQ);
  localparam int HW  = cnt_width(HOLD_CYCLES);
  localparam int GW  = cnt_width(GAP_CYCLES);
  localparam logic [HW-1:0] HOLD_RELOAD = HW'(HOLD_CYCLES - 1);
  localparam logic [GW-1:0] GAP_RELOAD  = GW'(GAP_CYCLES - 1);
  localparam logic [IW-1:0] LAST_INIT   = IW'(NUM_REQ - 1);

  disp_state_t         state;
  logic [HW-1:0]       hold_cnt;
  logic [GW-1:0]       gap_cnt;
  logic [IW-1:0]       last_grant;

  logic [NUM_REQ-1:0]  pick_grant;
  logic [IW-1:0]       pick_idx;
  logic                pick_valid;
  logic                owner_req;
  logic                other_req;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_picker (
    .req   (i_req),
    .last  (last_grant),
    .grant (pick_grant),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // Owner still wants the display / someone else is waiting for it
  always_comb begin
    owner_req = |(i_req & o_grant);
    other_req = |(i_req & ~o_grant);
  end

  // Digits of the current owner; all-zero while nobody owns the display
  always_comb begin
    o_hex = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (o_grant[r]) begin
        o_hex = o_hex | i_hex_data[r*DW +: DW];
      end
    end
  end

  // Ownership state machine: grant, hold/rotate, blank gap, idle
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state      <= ST_IDLE;
      o_grant    <= '0;
      o_busy     <= 1'b0;
      o_enable   <= 1'b0;
      hold_cnt   <= '0;
      gap_cnt    <= '0;
      last_grant <= LAST_INIT;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            state      <= ST_GRANT;
            o_grant    <= pick_grant;
            last_grant <= pick_idx;
            hold_cnt   <= HOLD_RELOAD;
            o_busy     <= 1'b1;
            o_enable   <= 1'b1;
          end
        end
        ST_GRANT: begin
          if (!owner_req || (((hold_cnt == '0) || i_next) && other_req)) begin
            state    <= ST_GAP;
            o_grant  <= '0;
            o_busy   <= 1'b0;
            o_enable <= 1'b0;
            gap_cnt  <= GAP_RELOAD;
          end else if (hold_cnt == '0) begin
            hold_cnt <= HOLD_RELOAD;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        ST_GAP: begin
          if (gap_cnt == '0) begin
            if (pick_valid) begin
              state      <= ST_GRANT;
              o_grant    <= pick_grant;
              last_grant <= pick_idx;
              hold_cnt   <= HOLD_RELOAD;
              o_busy     <= 1'b1;
              o_enable   <= 1'b1;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          o_grant  <= '0;
          o_busy   <= 1'b0;
          o_enable <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hex_display_arbiter.sv
// tb/tb_hex_display_arbiter.sv - randomized check of the arbiter against a reference model
module tb_hex_display_arbiter;

  localparam int NR   = 3;
  localparam int NH   = 6;
  localparam int HOLD = 8;
  localparam int GAP  = 2;
  localparam int DW   = NH * 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req;
  logic [NR*DW-1:0]  data;
  logic              nxt;
  logic [NR-1:0]     grant;
  logic [DW-1:0]     hex;
  logic              enable;
  logic              busy;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: owner index (-1 none), cycles shown so far, gap cycles left
  int m_owner, m_held, m_gap, m_last;
  logic [NR-1:0] seen_q[$];

  always #5 clk = ~clk;

  hex_display_arbiter #(
    .NUM_HEX     (NH),
    .NUM_REQ     (NR),
    .HOLD_CYCLES (HOLD),
    .GAP_CYCLES  (GAP)
  ) dut (
    .i_clock    (clk),
    .i_reset    (rst),
    .i_req      (req),
    .i_hex_data (data),
    .i_next     (nxt),
    .o_grant    (grant),
    .o_hex      (hex),
    .o_enable   (enable),
    .o_busy     (busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [NR-1:0] r, input int last);
    for (int k = 1; k <= NR; k++) begin
      if (r[(last + k) % NR]) return (last + k) % NR;
    end
    return -1;
  endfunction

  task automatic take_pick();
    int p;
    p = rr_pick(req, m_last);
    if (p >= 0) begin
      m_owner = p;
      m_last  = p;
      m_held  = 1;
    end
  endtask

  task automatic model_step();
    logic [NR-1:0] mine;
    bit others;
    if (rst) begin
      m_owner = -1; m_held = 0; m_gap = 0; m_last = NR - 1;
      return;
    end
    if (m_owner >= 0) begin
      mine   = '0;
      mine[m_owner] = 1'b1;
      others = (req & ~mine) != '0;
      if (!req[m_owner] || ((m_held == HOLD || nxt) && others)) begin
        m_owner = -1;
        m_gap   = GAP;
      end else if (m_held == HOLD) begin
        m_held = 1;
      end else begin
        m_held++;
      end
    end else if (m_gap > 0) begin
      if (m_gap == 1) begin
        m_gap = 0;
        take_pick();
      end else begin
        m_gap--;
      end
    end else begin
      take_pick();
    end
  endtask

  task automatic check_all();
    logic [NR-1:0] eg;
    logic [DW-1:0] eh;
    eg = '0;
    eh = '0;
    if (m_owner >= 0) begin
      eg[m_owner] = 1'b1;
      eh = data[m_owner*DW +: DW];
    end
    check("grant",  64'(grant),  64'(eg));
    check("hex",    64'(hex),    64'(eh));
    check("enable", 64'(enable), 64'(m_owner >= 0));
    check("busy",   64'(busy),   64'(m_owner >= 0));
    if (grant != '0 && (seen_q.size() == 0 || seen_q[$] != grant)) seen_q.push_back(grant);
    if (grant == '0 && seen_q.size() != 0 && seen_q[$] != '0) seen_q.push_back('0);
  endtask

  // drive at the falling edge, model the rising edge, check at the next falling edge
  task automatic cyc(input logic rs, input logic [NR-1:0] rq, input logic nx);
    rst = rs; req = rq; nxt = nx;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic default_data();
    for (int r = 0; r < NR; r++) data[r*DW +: DW] = 24'hA00000 | 24'(r);
  endtask

  initial begin
    logic [NR-1:0] rq;
    logic nx, rs;
    rst = 1'b1; req = '0; nxt = 1'b0;
    m_owner = -1; m_held = 0; m_gap = 0; m_last = NR - 1;
    default_data();

    // 1: reset, single requester, held without blank
    cyc(1'b1, 3'b000, 1'b0);
    check("rst_grant", 64'(grant), 64'h0);
    check("rst_hex", 64'(hex), 64'h0);
    check("rst_en", 64'(enable), 64'h0);
    cyc(1'b0, 3'b010, 1'b0);
    check("t1_grant", 64'(grant), 64'h2);
    check("t1_hex", 64'(hex), 64'hA00001);
    check("t1_en", 64'(enable), 64'h1);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 3'b010, 1'b0);
      check("t1_hold", 64'(busy), 64'h1);
    end

    // 2: all requesting rotates 001,010,100,001 with 2-cycle blanks
    cyc(1'b1, 3'b000, 1'b0);
    seen_q.delete();
    for (int i = 0; i < 3 * (HOLD + GAP) + 3; i++) cyc(1'b0, 3'b111, 1'b0);
    check("t2_len", 64'(seen_q.size()), 64'd7);
    if (seen_q.size() >= 7) begin
      check("t2_g0", 64'(seen_q[0]), 64'h1);
      check("t2_g1", 64'(seen_q[2]), 64'h2);
      check("t2_g2", 64'(seen_q[4]), 64'h4);
      check("t2_g3", 64'(seen_q[6]), 64'h1);
    end

    // 3: owner drops its request early
    cyc(1'b1, 3'b000, 1'b0);
    cyc(1'b0, 3'b101, 1'b0);
    cyc(1'b0, 3'b101, 1'b0);
    cyc(1'b0, 3'b101, 1'b0);
    cyc(1'b0, 3'b100, 1'b0);
    check("t3_gap", 64'(grant), 64'h0);
    cyc(1'b0, 3'b100, 1'b0);
    cyc(1'b0, 3'b100, 1'b0);
    check("t3_next", 64'(grant), 64'h4);

    // 4: next pulse with and without a competitor
    cyc(1'b1, 3'b000, 1'b0);
    cyc(1'b0, 3'b011, 1'b0);
    cyc(1'b0, 3'b011, 1'b1);
    check("t4_gap", 64'(grant), 64'h0);
    cyc(1'b0, 3'b011, 1'b0);
    cyc(1'b0, 3'b011, 1'b0);
    check("t4_rot", 64'(grant), 64'h2);
    cyc(1'b1, 3'b000, 1'b0);
    cyc(1'b0, 3'b001, 1'b0);
    cyc(1'b0, 3'b001, 1'b1);
    check("t4_keep", 64'(grant), 64'h1);
    for (int i = 0; i < 10; i++) cyc(1'b0, 3'b001, 1'b0);

    // 5: reset during gap and during grant
    cyc(1'b1, 3'b000, 1'b0);
    for (int i = 0; i < HOLD + 1; i++) cyc(1'b0, 3'b111, 1'b0);
    check("t5_in_gap", 64'(grant), 64'h0);
    cyc(1'b1, 3'b111, 1'b0);
    check("t5_rst_gap", 64'({grant, hex, enable, busy}), 64'h0);
    cyc(1'b0, 3'b111, 1'b0);
    check("t5_first", 64'(grant), 64'h1);
    for (int i = 0; i < HOLD + GAP + 3; i++) cyc(1'b0, 3'b111, 1'b0);
    cyc(1'b1, 3'b111, 1'b0);
    check("t5_rst_grant", 64'({grant, hex, enable, busy}), 64'h0);
    cyc(1'b0, 3'b111, 1'b0);
    check("t5_first2", 64'(grant), 64'h1);

    // 6: requests vanish during gap -> idle, then a fresh request
    for (int i = 0; i < HOLD; i++) cyc(1'b0, 3'b111, 1'b0);
    for (int i = 0; i < GAP + 3; i++) cyc(1'b0, 3'b000, 1'b0);
    check("t6_idle_hex", 64'(hex), 64'h0);
    cyc(1'b0, 3'b100, 1'b0);
    check("t6_grant", 64'(grant), 64'h4);

    // random traffic against the model
    rq = 3'b000;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(7) == 0) rq = NR'($urandom());
      nx = ($urandom_range(15) == 0);
      rs = ($urandom_range(249) == 0);
      if ($urandom_range(31) == 0) begin
        for (int r = 0; r < NR; r++) data[r*DW +: DW] = DW'($urandom());
      end
      cyc(rs, rq, nx);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
